data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Multicycle data-memory responder. It is the memory-side end of the MEM-stage load/store interface.
- Accepts one read or write request at a time from the MEM stage over MEM_R_EN/MEM_W_EN plus a byte address.
- Translates the byte address into a word index, waits a configurable access latency, then performs the access and pulses ready.
- Flags misaligned, out-of-range or conflicting requests with err instead of touching storage.

Parameters:
- BASE_ADDR, 1024, byte address of word 0 of data memory.
- DEPTH, 64, number of 32-bit words stored.
- LATENCY, 2, cycles from request acceptance to the access edge. Must be 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- MEM_R_EN  input  1  read request; held by requester until ready.
- MEM_W_EN  input  1  write request; held by requester until ready.
- addr  input  32  byte address (ALU result).
- write_val  input  32  store data.
- read_val  output  32  load data; valid while ready=1 for a read, held afterwards.
- ready  output  1  one-cycle completion pulse.
- err  output  1  error flag; valid only while ready=1.

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=0, err=0, read_val=0, counter=0, all DEPTH words cleared to 0. Takes effect immediately, not at the clock edge.
- Reset mid-operation: the request is aborted with no memory write and no ready pulse.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with MEM_R_EN|MEM_W_EN=1, latch addr, write_val and the op, set counter=LATENCY-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If counter>0: decrement counter.
  - If counter==0: perform the access (or error check) and go to DONE.
- DONE: ready=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: request accepted at edge t, access at edge t+LATENCY, ready high from edge t+LATENCY to edge t+LATENCY+1.
- Input sampling: inputs are sampled only at the accept edge. Changes to addr or write_val afterwards are ignored.
- Back-to-back requests: the requester must deassert its enables on the edge ending the ready cycle. Enables still high in IDLE start a new request, so the earliest back-to-back accept is edge t+LATENCY+2.
- Address map: off = addr - BASE_ADDR (32-bit unsigned, wraps), index = off[31:2].
- Error conditions, checked at the access edge on the latched request:
  - off[1:0] != 0 (misaligned)
  - index >= DEPTH (this also covers addr < BASE_ADDR via wrap)
  - MEM_R_EN and MEM_W_EN both high at acceptance
- On error: err=1 with ready, no write, read_val unchanged.
- Valid write: mem[index] <= write_val at the access edge, err=0, read_val unchanged.
- Valid read: read_val <= mem[index] at the access edge, err=0.
- Read after write to the same address in a later transaction returns the new data. There is no overlap of transactions.
- ready and err are both registered outputs.

Test Plan:
- Reset release: assert rst, release, idle 5 cycles -> ready=0, err=0, read_val=0 throughout.
- Write then read:
  - Write 0xDEADBEEF to addr 1028, accepted edge t -> ready=1, err=0 in cycle after edge t+2.
  - Then read 1028 -> read_val=0xDEADBEEF with ready.
  - Read 1032 -> read_val=0.
- Boundaries:
  - Write 0x12345678 to 1276 (index 63) then read back -> 0x12345678, err=0.
  - Read 1280 -> err=1, read_val unchanged.
  - Read 1020 (below base) -> err=1.
- Misaligned and conflict:
  - Write to 1030 -> err=1; a following read of 1028 returns the prior value.
  - Both enables high at 1028 -> err=1, no write.
- Input change after accept:
  - Accept a write at 1036 with 0xAAAA0000, then change addr to 1040 and data to 0x5555 during WAIT -> 1036 holds 0xAAAA0000, 1040 holds 0.
- Reset mid-operation:
  - Pulse rst asynchronously (between edges) during WAIT of a write of 0xCAFEF00D to 1024 -> outputs zero immediately, no ready pulse.
  - Subsequent read of 1024 -> 0.

Source files
------------

// File: rtl/data_memory_responder.sv
// Memory-side end of the MEM-stage load/store handshake: one request at a time,
// a fixed access latency, then a one-cycle ready pulse with an error flag.
module data_memory_responder #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned LATENCY   = 2    // legal range 1..15 (4-bit countdown)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] addr,
  input  logic [31:0] write_val,
  output logic [31:0] read_val,
  output logic        ready,
  output logic        err
);

  localparam int unsigned IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);
  localparam logic [3:0]  CNT_INIT    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_val_q, read_val_d;
  logic        op_wr_q, op_wr_d;
  logic        conflict_q, conflict_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic [31:0]      off_s;
  logic [IDX_W-1:0] idx_s;
  logic             req_err_s;
  logic             we_s;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  function automatic logic access_error(input logic [31:0] off, input logic conflict);
    access_error = (off[1:0] != 2'd0) || (off[31:2] >= DEPTH_WORDS) || conflict;
  endfunction

  assign off_s     = addr_q - BASE_ADDR;
  assign idx_s     = off_s[IDX_W+1:2];
  assign req_err_s = access_error(off_s, conflict_q);

  // Next-state, request latching, access decision and output next values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    conflict_d = conflict_q;
    read_val_d = read_val_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    we_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MEM_R_EN || MEM_W_EN) begin
          state_d    = ST_WAIT;
          cnt_d      = CNT_INIT;
          addr_d     = addr;
          wdata_d    = write_val;
          op_wr_d    = MEM_W_EN;
          conflict_d = MEM_R_EN && MEM_W_EN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          if (req_err_s) begin
            err_d = 1'b1;
          end else if (op_wr_q) begin
            we_s = 1'b1;
          end else begin
            read_val_d = mem_q[idx_s];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      op_wr_q    <= 1'b0;
      conflict_q <= 1'b0;
      read_val_q <= 32'd0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_wr_q    <= op_wr_d;
      conflict_q <= conflict_d;
      read_val_q <= read_val_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  // Storage array; cleared by reset so an aborted write leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (we_s) begin
      mem_q[idx_s] <= wdata_q;
    end else begin
      mem_q[idx_s] <= mem_q[idx_s];
    end
  end

  assign read_val = read_val_q;
  assign ready    = ready_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: directed test-plan sequence plus randomized requests
// checked against an array-based reference model of the memory.
module tb_data_memory_responder;

  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          DEPTH = 64;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_en = 1'b0;
  logic        w_en = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wval = 32'd0;
  logic [31:0] rval;
  logic        rdy;
  logic        er;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rv;

  data_memory_responder #(
    .BASE_ADDR(BASE),
    .DEPTH    (DEPTH),
    .LATENCY  (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MEM_R_EN (r_en),
    .MEM_W_EN (w_en),
    .addr     (addr),
    .write_val(wval),
    .read_val (rval),
    .ready    (rdy),
    .err      (er)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    ref_rv = 32'd0;
  endtask

  // One complete transaction; scramble changes addr/data right after acceptance.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble, input string tag);
    logic [31:0] off;
    logic        e;
    int          cyc;
    @(negedge clk);
    r_en = r; w_en = w; addr = a; wval = d;
    @(posedge clk); #1;
    if (scramble) begin
      addr = a + 32'd4;
      wval = 32'h0000_5555;
    end
    off = a - BASE;
    e   = (off[1:0] != 2'd0) || ((off >> 2) >= DEPTH) || (r && w);
    if (!e) begin
      if (w) ref_mem[off >> 2] = d;
      else   ref_rv = ref_mem[off >> 2];
    end
    cyc = 0;
    while (rdy !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val({tag, "/latency"}, cyc, LAT);
    check_val({tag, "/err"}, {31'd0, er}, {31'd0, e});
    check_val({tag, "/read_val"}, rval, ref_rv);
    @(negedge clk);
    r_en = 1'b0; w_en = 1'b0;
    @(posedge clk); #1;
    check_val({tag, "/pulse"}, {31'd0, rdy}, 32'd0);
  endtask

  initial begin
    int          idx;
    int          kind;
    logic [31:0] a;
    ref_clear();

    #1;
    check_val("rst/ready", {31'd0, rdy}, 32'd0);
    check_val("rst/err", {31'd0, er}, 32'd0);
    check_val("rst/read_val", rval, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("idle/ready", {31'd0, rdy}, 32'd0);
      check_val("idle/err", {31'd0, er}, 32'd0);
      check_val("idle/read_val", rval, 32'd0);
    end

    do_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, "wr1028");
    do_req(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, "rd1028");
    do_req(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, "rd1032");
    do_req(1'b0, 1'b1, 32'd1276, 32'h12345678, 1'b0, "wr_top");
    do_req(1'b1, 1'b0, 32'd1276, 32'h0, 1'b0, "rd_top");
    do_req(1'b1, 1'b0, 32'd1280, 32'h0, 1'b0, "rd_past_end");
    do_req(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0, "rd_below_base");
    do_req(1'b0, 1'b1, 32'd1030, 32'h11111111, 1'b0, "wr_misaligned");
    do_req(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, "rd_after_misaligned");
    do_req(1'b1, 1'b1, 32'd1028, 32'h0BADF00D, 1'b0, "both_en");
    do_req(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, "rd_after_conflict");
    do_req(1'b0, 1'b1, 32'd1036, 32'hAAAA0000, 1'b1, "wr_scrambled");
    do_req(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, "rd1036");
    do_req(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, "rd1040");

    @(negedge clk);
    w_en = 1'b1; addr = 32'd1024; wval = 32'hCAFEF00D;
    @(posedge clk); #3;
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0;
    #1;
    check_val("midrst/read_val", rval, 32'd0);
    check_val("midrst/ready", {31'd0, rdy}, 32'd0);
    check_val("midrst/err", {31'd0, er}, 32'd0);
    ref_clear();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_val("midrst/no_ready", {31'd0, rdy}, 32'd0);
    end
    do_req(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, "rd1024_after_rst");
    do_req(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, "rd1028_after_rst");

    for (int n = 0; n < 150; n++) begin
      idx  = $urandom_range(0, 69) - 3;
      a    = BASE + 32'(idx * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      kind = $urandom_range(0, 9);
      do_req(kind < 5 || kind == 9, kind >= 5, a, $urandom, $urandom_range(0, 3) == 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
